vending_ctrl_fsm: RTL

// - Top-level sequencer for the vending-machine datapath: drives the 4-bit state code the calculation block decodes.
// - Walks customer flow (select -> quantity -> pay -> dispense/refund) and admin flow (select -> restock qty -> commit / clear).
// - Applies the pay timeout and guards one-shot commit codes so the datapath updates exactly once per transaction.

---
 rtl/vm_pkg.sv | 42 ++++
 rtl/vm_timer.sv | 33 +++
 rtl/vending_ctrl_fsm.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine controller and its datapath:
// state codes decoded by the calculation block, and the item price table.
package vm_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE     = 4'b0000;
    localparam logic [STATE_W-1:0] ST_SEL      = 4'b0001;
    localparam logic [STATE_W-1:0] ST_QTY      = 4'b0011;
    localparam logic [STATE_W-1:0] ST_PAY      = 4'b0010;
    localparam logic [STATE_W-1:0] ST_DISP     = 4'b0110;
    localparam logic [STATE_W-1:0] ST_DONE     = 4'b0100;
    localparam logic [STATE_W-1:0] ST_REFUND   = 4'b0101;
    localparam logic [STATE_W-1:0] ST_A_SEL    = 4'b1101;
    localparam logic [STATE_W-1:0] ST_A_QTY    = 4'b1111;
    localparam logic [STATE_W-1:0] ST_A_COMMIT = 4'b1011;
    localparam logic [STATE_W-1:0] ST_A_CLEAR  = 4'b1110;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = ST_IDLE,
        S_SEL      = ST_SEL,
        S_QTY      = ST_QTY,
        S_PAY      = ST_PAY,
        S_DISP     = ST_DISP,
        S_DONE     = ST_DONE,
        S_REFUND   = ST_REFUND,
        S_A_SEL    = ST_A_SEL,
        S_A_QTY    = ST_A_QTY,
        S_A_COMMIT = ST_A_COMMIT,
        S_A_CLEAR  = ST_A_CLEAR
    } state_t;

    localparam int PRICE_W = 7;
    localparam int N_ITEMS = 4;
    localparam logic [PRICE_W-1:0] PRICE_TABLE [N_ITEMS] = '{7'd3, 7'd5, 7'd6, 7'd10};

    // States in which the shared down-counter is running.
    function automatic logic is_timed(input state_t s);
        return (s == S_PAY) || (s == S_DONE) || (s == S_REFUND);
    endfunction

endpackage

// File: rtl/vm_timer.sv
// Saturating down-counter shared by the pay timeout and the display hold.
// Cleared whenever it is not running, so it reads 0 outside the timed states.
module vm_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_next
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

    // High when this cycle's decrement lands on (or is already at) zero.
    assign zero_next = (count <= CNT_W'(1));

endmodule

// File: rtl/vending_ctrl_fsm.sv
// Vending-machine sequencer: customer and admin flows, pay timeout, and
// registered one-shot dispense/refund pulses driven alongside the state code.
module vending_ctrl_fsm
    import vm_pkg::*;
#(
    parameter int PAY_TIMEOUT = 1000,
    parameter int SHOW_CYC    = 200,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         confirm,
    input  logic         cancel,
    input  logic         admin_key,
    input  logic         coin_any,
    input  logic         sold_out,
    input  logic [6:0]   sum,
    input  logic [6:0]   money,
    output logic [3:0]   state,
    output logic         dispense,
    output logic         refund,
    output logic         busy
);

    state_t           state_q;
    state_t           state_d;
    logic             dispense_q;
    logic             refund_q;
    logic             busy_q;
    logic             paid;
    logic             tmr_load;
    logic             tmr_run;
    logic             tmr_end;
    logic [CNT_W-1:0] tmr_val;

    assign paid = (sum >= money) && (money != '0);

    vm_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .run       (tmr_run),
        .load_val  (tmr_val),
        .zero_next (tmr_end)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (admin_key)    state_d = S_A_SEL;
                else if (confirm) state_d = S_SEL;
            end
            S_SEL: begin
                if (cancel)                    state_d = S_IDLE;
                else if (confirm && !sold_out) state_d = S_QTY;
            end
            S_QTY: begin
                if (cancel)       state_d = S_SEL;
                else if (confirm) state_d = S_PAY;
            end
            // Payment completion outranks cancel; a coin outranks expiry.
            S_PAY: begin
                if (paid)                      state_d = S_DISP;
                else if (cancel)               state_d = S_REFUND;
                else if (!coin_any && tmr_end) state_d = S_REFUND;
            end
            S_DISP:   state_d = S_DONE;
            S_DONE: begin
                if (confirm || tmr_end) state_d = S_IDLE;
            end
            S_REFUND: begin
                if (tmr_end) state_d = S_IDLE;
            end
            S_A_SEL: begin
                if (!admin_key)   state_d = S_IDLE;
                else if (cancel)  state_d = S_A_CLEAR;
                else if (confirm) state_d = S_A_QTY;
            end
            S_A_QTY: begin
                if (!admin_key)   state_d = S_IDLE;
                else if (cancel)  state_d = S_A_SEL;
                else if (confirm) state_d = S_A_COMMIT;
            end
            // One-shot commit codes always finish before the key is honoured.
            S_A_COMMIT, S_A_CLEAR: state_d = S_A_SEL;
            default:               state_d = S_IDLE;
        endcase

        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_run  = is_timed(state_d);
        if (state_d == S_PAY && (state_q != S_PAY || coin_any)) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(PAY_TIMEOUT);
        end else if ((state_d == S_DONE || state_d == S_REFUND) && state_d != state_q) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SHOW_CYC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dispense_q <= 1'b0;
            refund_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dispense_q <= (state_d == S_DISP);
            refund_q   <= (state_d == S_REFUND) && (state_q != S_REFUND);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign state    = state_q;
    assign dispense = dispense_q;
    assign refund   = refund_q;
    assign busy     = busy_q;

endmodule
